// File: rtl/light_row_duel.sv
// light_row_duel: tug-of-war cursor on one LED matrix row.
// Two players push a single lit pixel toward their own edge. Pushing it off
// the edge wins the round. The first player to reach the top score locks the
// match until a restart. WRAP=1 turns this into a practice mode where the
// cursor wraps around and nobody wins.
module light_row_duel #(
    parameter int WIDTH       = 16,
    parameter int SCORE_W     = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP        = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               lk,
    input  logic               rk,
    input  logic               restart,
    output logic [WIDTH-1:0]   red_row,
    output logic [WIDTH-1:0]   grn_row,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic [1:0]         winner
);

    localparam int PW = $clog2(WIDTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0]      CENTRE    = PW'(WIDTH / 2);
    localparam logic [PW-1:0]      LAST      = PW'(WIDTH - 1);
    localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX       = '1;
    localparam logic [WIDTH-1:0]   GRN_IDLE  = WIDTH'(1) << CENTRE;

    localparam logic [1:0] S_PLAY = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

    // Score increment that sticks at the top value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == MAX) ? MAX : s + SCORE_W'(1);
    endfunction

    // Key bundle ordering inside the synchroniser: {restart, rk, lk}.
    // Index 0 is the newest sample, SYNC_STAGES-1 the settled one.
    logic [SYNC_STAGES-1:0][2:0] key_sync_p0;
    logic [2:0]                  key_prev_p1;
    logic [2:0]                  key_edge;
    logic                        lp;
    logic                        rp;
    logic                        rs;

    logic [1:0]         state,    state_n;
    logic [PW-1:0]      pos,      pos_n;
    logic [HW-1:0]      hold_cnt, hold_cnt_n;
    logic [SCORE_W-1:0] l_n,      r_n;
    logic [1:0]         win_n;
    logic [WIDTH-1:0]   red_n,    grn_n;

    // Synchronise the raw keys and remember the last settled sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_sync_p0 <= '0;
            key_prev_p1 <= '0;
        end else begin
            key_sync_p0 <= {key_sync_p0[SYNC_STAGES-2:0], {restart, rk, lk}};
            key_prev_p1 <= key_sync_p0[SYNC_STAGES-1];
        end
    end

    // --- stage boundary: settled keys -> one-cycle press pulses ---
    assign key_edge = key_sync_p0[SYNC_STAGES-1] & ~key_prev_p1;
    // Simultaneous pushes from both sides cancel out.
    assign lp = key_edge[0] & ~key_edge[1];
    assign rp = key_edge[1] & ~key_edge[0];
    assign rs = key_edge[2];

    // Round/match control: restart first, then per-state behaviour.
    always_comb begin
        state_n    = state;
        pos_n      = pos;
        hold_cnt_n = hold_cnt;
        l_n        = l_score;
        r_n        = r_score;
        win_n      = winner;
        if (rs) begin
            state_n    = S_PLAY;
            pos_n      = CENTRE;
            hold_cnt_n = '0;
            l_n        = '0;
            r_n        = '0;
            win_n      = WIN_NONE;
        end else begin
            case (state)
                S_PLAY: begin
                    if (lp) begin
                        if (pos != LAST) begin
                            pos_n = pos + PW'(1);
                        end else if (WRAP != 0) begin
                            pos_n = '0;
                        end else begin
                            l_n   = sat_inc(l_score);
                            win_n = WIN_L;
                            if (sat_inc(l_score) == MAX) begin
                                state_n = S_OVER;
                            end else begin
                                state_n    = S_HOLD;
                                hold_cnt_n = HOLD_LOAD;
                            end
                        end
                    end else if (rp) begin
                        if (pos != '0) begin
                            pos_n = pos - PW'(1);
                        end else if (WRAP != 0) begin
                            pos_n = LAST;
                        end else begin
                            r_n   = sat_inc(r_score);
                            win_n = WIN_R;
                            if (sat_inc(r_score) == MAX) begin
                                state_n = S_OVER;
                            end else begin
                                state_n    = S_HOLD;
                                hold_cnt_n = HOLD_LOAD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state_n = S_PLAY;
                        pos_n   = CENTRE;
                        win_n   = WIN_NONE;
                    end else begin
                        hold_cnt_n = hold_cnt - HW'(1);
                    end
                end
                S_OVER: begin
                    state_n = S_OVER;
                end
                default: begin
                    state_n = S_PLAY;
                    pos_n   = CENTRE;
                    win_n   = WIN_NONE;
                end
            endcase
        end
    end

    // Pixel pattern for the upcoming state, so the row register updates
    // on the same edge as the game state it depicts.
    always_comb begin
        red_n = '0;
        grn_n = '0;
        if (state_n == S_PLAY) begin
            grn_n = WIDTH'(1) << pos_n;
        end else if (win_n == WIN_L) begin
            red_n = '1;
        end else begin
            grn_n = '1;
        end
    end

    // --- stage boundary: game state and registered row/score outputs ---
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_PLAY;
            pos      <= CENTRE;
            hold_cnt <= '0;
            l_score  <= '0;
            r_score  <= '0;
            winner   <= WIN_NONE;
            red_row  <= '0;
            grn_row  <= GRN_IDLE;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            hold_cnt <= hold_cnt_n;
            l_score  <= l_n;
            r_score  <= r_n;
            winner   <= win_n;
            red_row  <= red_n;
            grn_row  <= grn_n;
        end
    end

endmodule
